// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: states, opcodes,
// functs, ALU op codes, mux selects and exception cause codes.
// Pure declarations; no logic, no latency, no flow control.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_EXC    = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_EXC    = 2'b11;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_OVF  = 2'b01;
    localparam logic [1:0] CAUSE_RSVD = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct decoder: ALU op code, reserved-funct flag, overflow-trap enable.
// Latency: purely combinational.
// Backpressure: none.
// Ports: funct (in, 6) -> alu_control (out, 3), illegal (out, 1), ovf_check (out, 1).
module alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       illegal,
    output logic       ovf_check
);

    always_comb begin
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        ovf_check   = 1'b0;
        case (funct)
            FN_ADD: begin alu_control = ALU_ADD; ovf_check = 1'b1; end
            FN_SUB: begin alu_control = ALU_SUB; ovf_check = 1'b1; end
            FN_AND: alu_control = ALU_AND;
            FN_OR:  alu_control = ALU_OR;
            FN_SLT: alu_control = ALU_SLT;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle MIPS core (fetch/decode/execute/mem/writeback, traps).
// Latency: outputs combinational from state+inputs; lw 5, sw/R/addi 4, beq/j 3 cycles.
// Backpressure: mem_ready low holds FETCH/MEMRD/MEMWR with strobes stable (MEM_WAIT_EN=1).
// Ports: clk, rst_n; opcode/funct from IR, zero/overflow from ALU, mem_ready; datapath
//        enables/selects, alu_control, exception pulse + held exc_cause, debug state.
module multicycle_controller
    import mips_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero_flag,
    input  logic       overflow_flag,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] pc_src,
    output logic       exception,
    output logic [1:0] exc_cause,
    output logic [3:0] state
);

    state_e     state_q, state_d;
    logic [1:0] cause_q, cause_d;

    logic [2:0] dec_alu_control;
    logic       dec_illegal;
    logic       dec_ovf_check;
    logic       rdy;

    // With single-cycle memory every access completes immediately.
    assign rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

    alu_decoder u_alu_decoder (
        .funct       (funct),
        .alu_control (dec_alu_control),
        .illegal     (dec_illegal),
        .ovf_check   (dec_ovf_check)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    // Raw decode; forced to zero below while reset is asserted.
    logic       pc_write_c, i_or_d_c, mem_read_c, mem_write_c, ir_write_c;
    logic       reg_dst_c, mem_to_reg_c, reg_write_c, alu_src_a_c, exception_c;
    logic [1:0] alu_src_b_c, pc_src_c;
    logic [2:0] alu_control_c;

    always_comb begin
        state_d       = state_q;
        cause_d       = cause_q;
        pc_write_c    = 1'b0;
        i_or_d_c      = 1'b0;
        mem_read_c    = 1'b0;
        mem_write_c   = 1'b0;
        ir_write_c    = 1'b0;
        reg_dst_c     = 1'b0;
        mem_to_reg_c  = 1'b0;
        reg_write_c   = 1'b0;
        alu_src_a_c   = 1'b0;
        exception_c   = 1'b0;
        alu_src_b_c   = SRCB_B;
        pc_src_c      = PCSRC_ALU;
        alu_control_c = ALU_ADD;

        case (state_q)
            S_FETCH: begin
                mem_read_c  = 1'b1;
                alu_src_b_c = SRCB_FOUR;
                ir_write_c  = rdy;
                pc_write_c  = rdy;
                if (rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Branch target computed speculatively into ALUOut.
                alu_src_b_c = SRCB_IMMSH2;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE: begin
                        if (dec_illegal) begin
                            state_d = S_EXC;
                            cause_d = CAUSE_RSVD;
                        end else begin
                            state_d = S_EXEC;
                        end
                    end
                    OP_BEQ:  state_d = S_BRANCH;
                    OP_ADDI: state_d = S_ADDIEX;
                    OP_J:    state_d = S_JUMP;
                    default: begin
                        state_d = S_EXC;
                        cause_d = CAUSE_RSVD;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = SRCB_IMM;
                if (opcode == OP_SW) state_d = S_MEMWR;
                else                 state_d = S_MEMRD;
            end
            S_MEMRD: begin
                mem_read_c = 1'b1;
                i_or_d_c   = 1'b1;
                if (rdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                mem_write_c = 1'b1;
                i_or_d_c    = 1'b1;
                if (rdy) state_d = S_FETCH;
            end
            S_EXEC: begin
                alu_src_a_c   = 1'b1;
                alu_control_c = dec_alu_control;
                // Overflow only matters for signed add/sub.
                if (overflow_flag && dec_ovf_check) begin
                    state_d = S_EXC;
                    cause_d = CAUSE_OVF;
                end else begin
                    state_d = S_ALUWB;
                end
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                reg_dst_c   = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_c   = 1'b1;
                alu_control_c = ALU_SUB;
                pc_src_c      = PCSRC_ALUOUT;
                pc_write_c    = zero_flag;
                state_d       = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = SRCB_IMM;
                if (overflow_flag) begin
                    state_d = S_EXC;
                    cause_d = CAUSE_OVF;
                end else begin
                    state_d = S_ADDIWB;
                end
            end
            S_ADDIWB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                pc_write_c = 1'b1;
                pc_src_c   = PCSRC_JUMP;
                state_d    = S_FETCH;
            end
            S_EXC: begin
                exception_c = 1'b1;
                pc_write_c  = 1'b1;
                pc_src_c    = PCSRC_EXC;
                state_d     = S_FETCH;
            end
            // Unused encodings recover to FETCH with all outputs idle.
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write    = rst_n & pc_write_c;
        i_or_d      = rst_n & i_or_d_c;
        mem_read    = rst_n & mem_read_c;
        mem_write   = rst_n & mem_write_c;
        ir_write    = rst_n & ir_write_c;
        reg_dst     = rst_n & reg_dst_c;
        mem_to_reg  = rst_n & mem_to_reg_c;
        reg_write   = rst_n & reg_write_c;
        alu_src_a   = rst_n & alu_src_a_c;
        exception   = rst_n & exception_c;
        alu_src_b   = rst_n ? alu_src_b_c   : 2'b00;
        pc_src      = rst_n ? pc_src_c      : 2'b00;
        alu_control = rst_n ? alu_control_c : 3'b000;
        exc_cause   = rst_n ? cause_q       : 2'b00;
        state       = state_q;
    end

endmodule
